wshb_arbiter: RTL and testbench
===============================

# wshb_arbiter

Round-robin Wishbone arbiter that shares one Wishbone slave port (the SDRAM controller) between NM requesting masters, such as the mire pattern generator and the VGA frame reader. A grant is held for the whole bus cycle of the owning master. A configurable hold limit preempts a long-running owner at a burst boundary so that no requester starves. Request and response signals pass combinationally while a grant is held, so arbitration adds no data-path latency.

## Interface
- NM, 2, number of masters (2..8)
- AW, 32, address width
- DW, 32, data width; sel width is DW/8
- MAX_HOLD, 256, owner terminations before preemption is allowed; 0 disables preemption
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- m_cyc, m_stb, m_we  in  NM each  per-master cycle, strobe, write enable
- m_adr  in  NM*AW  per-master address, master i in bits [i*AW +: AW]
- m_dat_ms  in  NM*DW  per-master write data
- m_sel  in  NM*DW/8  per-master byte selects
- m_cti  in  NM*3  per-master cycle type; m_bte  in  NM*2  per-master burst type
- m_ack, m_err, m_rty  out  NM each  per-master terminations
- m_dat_sm  out  NM*DW  per-master read data
- s_cyc, s_stb, s_we, s_adr, s_dat_ms, s_sel, s_cti, s_bte  out  slave-side copies, same widths as one master
- s_ack, s_err, s_rty  in  1 each; s_dat_sm  in  DW
- gnt  out  NM  one-hot current owner; all zero when no owner

## Operation
- State machine with two states, IDLE and OWN. Registers: state, owner index, last index, hold counter (saturating, clog2(MAX_HOLD+1) bits).
- Reset: state=IDLE, last=NM-1, counter=0, so master 0 wins the first arbitration.
- IDLE
  - All s_* outputs are 0; all m_ack/err/rty/dat_sm are 0; gnt=0.
  - If any m_cyc is 1, pick the first i with m_cyc[i]=1, scanning last+1, last+2, ... modulo NM.
  - On that edge: owner=i, last=i, counter=0, state goes to OWN.
- OWN
  - All s_* outputs equal the owner's m_* inputs.
  - s_ack/err/rty/dat_sm go to the owner only; every other master sees 0.
  - gnt[owner]=1.
  - The counter increments on each owner termination (s_ack|s_err|s_rty) and saturates at MAX_HOLD.
- Release: m_cyc[owner]=0 at an edge moves the state to IDLE.
- Preemption: move to IDLE when all of the following hold:
  - MAX_HOLD≠0;
  - the counter is at MAX_HOLD, or reaches it on this termination;
  - a termination occurs this cycle with owner cti equal to 3'b000 or 3'b111;
  - another master has m_cyc=1.
- The preempted master keeps cyc/stb asserted and simply sees no ack until regranted. This is legal Wishbone stall behaviour.
- Because last=previous owner, a preempted master ranks last at the next arbitration.
- A termination inside an incrementing burst (cti=3'b010) never preempts; the switch waits for the end-of-burst termination.
- Arbitration ignores m_stb and uses only m_cyc.

## Timing
- Grant latency: m_cyc rises before edge t; gnt and s_cyc are valid after edge t (1 cycle).
- Ownership switch (release or preemption): exactly one bubble cycle in IDLE with s_cyc=0, then the new owner is forwarded.
- Back-to-back requester after release: the new owner drives s_cyc 2 cycles after the old owner's cyc falls.
- The data path is combinational in OWN: s_ack in cycle n appears on m_ack[owner] in cycle n.
- The owner dropping m_cyc in the same cycle as a termination: the termination is still routed to it; then the state goes to IDLE.
- Asynchronous rst mid-transfer: all outputs go to 0 immediately and the state goes to IDLE. Masters must restart their cycles.

## Test plan
- Reset: assert rst with m_cyc=2'b11 -> gnt=0, s_cyc=0, all m_ack=0. After release, gnt=2'b01 one cycle later.
- Single master: master 1 issues a write to adr 0x100 with data 0xDEADBEEF and the slave acks after 3 wait states -> s_adr=0x100, s_dat_ms=0xDEADBEEF, m_ack[1] pulses once, m_ack[0]=0 throughout.
- Contention: both masters raise cyc in the same cycle -> master 0 is served. Master 0 drops cyc; one s_cyc=0 bubble; then gnt=2'b10. On the next simultaneous request, master 0 wins (round robin).
- Preemption: MAX_HOLD=4; master 0 runs continuous 8-beat bursts (cti 010…111) while master 1 holds cyc -> switch after the first burst's 111-termination at or after count 4, never mid-burst. Master 0 is regranted after master 1 releases.
- Error routing: the slave returns s_err with s_dat_sm=0x12345678 to owner 1 -> m_err=2'b10, m_dat_sm for master 1 = 0x12345678, master 0 read data = 0.
- MAX_HOLD=0: master 0 holds cyc for 1000 acks with master 1 requesting -> no switch until master 0 drops cyc.

Source files
------------

// File: rtl/wshb_arbiter.sv
// Round-robin Wishbone arbiter: NM masters share one slave port, and a grant lasts for the owner's bus cycle.
// A hold limit may preempt a long-running owner at a burst boundary, and the data path stays combinational while a grant is held.
module wshb_arbiter #(
    parameter int NM       = 2,
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_HOLD = 256
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NM-1:0]          m_cyc,
    input  logic [NM-1:0]          m_stb,
    input  logic [NM-1:0]          m_we,
    input  logic [NM*AW-1:0]       m_adr,
    input  logic [NM*DW-1:0]       m_dat_ms,
    input  logic [NM*(DW/8)-1:0]   m_sel,
    input  logic [NM*3-1:0]        m_cti,
    input  logic [NM*2-1:0]        m_bte,
    output logic [NM-1:0]          m_ack,
    output logic [NM-1:0]          m_err,
    output logic [NM-1:0]          m_rty,
    output logic [NM*DW-1:0]       m_dat_sm,
    output logic                   s_cyc,
    output logic                   s_stb,
    output logic                   s_we,
    output logic [AW-1:0]          s_adr,
    output logic [DW-1:0]          s_dat_ms,
    output logic [DW/8-1:0]        s_sel,
    output logic [2:0]             s_cti,
    output logic [1:0]             s_bte,
    input  logic                   s_ack,
    input  logic                   s_err,
    input  logic                   s_rty,
    input  logic [DW-1:0]          s_dat_sm,
    output logic [NM-1:0]          gnt
);

    localparam int SW = DW / 8;
    localparam int IW = (NM > 1) ? $clog2(NM) : 1;
    localparam int CW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [CW-1:0] HOLD_MAX = CW'(MAX_HOLD);
    localparam logic [IW-1:0] LAST_RST = IW'(NM - 1);

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] owner_q, owner_d;
    logic [IW-1:0] last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [AW-1:0] adr_a [NM];
    logic [DW-1:0] dat_a [NM];
    logic [SW-1:0] sel_a [NM];
    logic [2:0]    cti_a [NM];
    logic [1:0]    bte_a [NM];

    logic [NM-1:0] own_oh;
    logic [IW-1:0] pick;
    logic          found;
    logic          term;
    logic          others_req;
    logic          burst_end;
    logic          at_limit;
    logic          preempt;
    logic [CW-1:0] cnt_inc;

    function automatic logic [IW-1:0] rr_idx(input logic [IW-1:0] base, input int k);
        return IW'((int'(base) + k) % NM);
    endfunction

    for (genvar i = 0; i < NM; i++) begin : g_unpack
        assign adr_a[i] = m_adr[i*AW +: AW];
        assign dat_a[i] = m_dat_ms[i*DW +: DW];
        assign sel_a[i] = m_sel[i*SW +: SW];
        assign cti_a[i] = m_cti[i*3 +: 3];
        assign bte_a[i] = m_bte[i*2 +: 2];
    end

    // Round-robin search starting just after the previous owner
    always_comb begin
        pick  = last_q;
        found = 1'b0;
        for (int k = 1; k <= NM; k++) begin
            if (!found && m_cyc[rr_idx(last_q, k)]) begin
                pick  = rr_idx(last_q, k);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        own_oh = '0;
        for (int i = 0; i < NM; i++) begin
            own_oh[i] = (state_q == OWN) && (owner_q == IW'(i));
        end
    end

    assign gnt = own_oh;

    always_comb begin
        s_cyc    = 1'b0;
        s_stb    = 1'b0;
        s_we     = 1'b0;
        s_adr    = '0;
        s_dat_ms = '0;
        s_sel    = '0;
        s_cti    = '0;
        s_bte    = '0;
        if (state_q == OWN) begin
            s_cyc    = m_cyc[owner_q];
            s_stb    = m_stb[owner_q];
            s_we     = m_we[owner_q];
            s_adr    = adr_a[owner_q];
            s_dat_ms = dat_a[owner_q];
            s_sel    = sel_a[owner_q];
            s_cti    = cti_a[owner_q];
            s_bte    = bte_a[owner_q];
        end
    end

    always_comb begin
        m_ack    = '0;
        m_err    = '0;
        m_rty    = '0;
        m_dat_sm = '0;
        for (int i = 0; i < NM; i++) begin
            m_ack[i]           = own_oh[i] & s_ack;
            m_err[i]           = own_oh[i] & s_err;
            m_rty[i]           = own_oh[i] & s_rty;
            m_dat_sm[i*DW +: DW] = own_oh[i] ? s_dat_sm : '0;
        end
    end

    // Preemption only at a single-beat or end-of-burst termination, once the hold budget is spent
    assign term       = s_ack | s_err | s_rty;
    assign others_req = |(m_cyc & ~own_oh);
    assign burst_end  = (s_cti == 3'b000) || (s_cti == 3'b111);
    assign cnt_inc    = (cnt_q == HOLD_MAX) ? cnt_q : cnt_q + CW'(1);
    assign at_limit   = (cnt_q == HOLD_MAX) || (cnt_inc == HOLD_MAX);
    assign preempt    = (MAX_HOLD != 0) && term && burst_end && at_limit && others_req;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = OWN;
                    owner_d = pick;
                    last_d  = pick;
                    cnt_d   = '0;
                end
            end
            OWN: begin
                if (term) begin
                    cnt_d = cnt_inc;
                end
                if (!m_cyc[owner_q] || preempt) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= LAST_RST;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_wshb_arbiter.sv
// Bench for wshb_arbiter: two instances (hold limit 4 and hold limit 0) share one set of master and slave stimulus.
// Each expected cycle is queued when it is driven, then popped and compared while the clock is low.
module tb_wshb_arbiter;

    localparam int NM = 2;
    localparam int AW = 32;
    localparam int DW = 32;

    localparam logic [31:0] ADR0 = 32'h0000_0040;
    localparam logic [31:0] ADR1 = 32'h0000_0100;
    localparam logic [31:0] DAT0 = 32'hA5A5_0001;
    localparam logic [31:0] DAT1 = 32'hDEAD_BEEF;
    localparam logic [3:0]  SEL0 = 4'h3;
    localparam logic [3:0]  SEL1 = 4'hF;
    localparam logic [1:0]  BTE0 = 2'b01;
    localparam logic [1:0]  BTE1 = 2'b10;
    localparam logic [31:0] SDAT = 32'h1234_5678;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [NM-1:0]        m_cyc, m_stb, m_we;
    logic [NM*AW-1:0]     m_adr;
    logic [NM*DW-1:0]     m_dat_ms;
    logic [NM*(DW/8)-1:0] m_sel;
    logic [NM*3-1:0]      m_cti;
    logic [NM*2-1:0]      m_bte;
    logic                 s_ack, s_err, s_rty;
    logic [DW-1:0]        s_dat_sm;

    logic [NM-1:0]    a_ack, a_err, a_rty, a_gnt;
    logic [NM*DW-1:0] a_dat_sm;
    logic             a_cyc, a_stb, a_we;
    logic [AW-1:0]    a_adr;
    logic [DW-1:0]    a_dat;
    logic [DW/8-1:0]  a_sel;
    logic [2:0]       a_cti;
    logic [1:0]       a_bte;

    logic [NM-1:0]    b_ack, b_err, b_rty, b_gnt;
    logic [NM*DW-1:0] b_dat_sm;
    logic             b_cyc, b_stb, b_we;
    logic [AW-1:0]    b_adr;
    logic [DW-1:0]    b_dat;
    logic [DW/8-1:0]  b_sel;
    logic [2:0]       b_cti;
    logic [1:0]       b_bte;

    wshb_arbiter #(.NM(NM), .AW(AW), .DW(DW), .MAX_HOLD(4)) dut (
        .clk(clk), .rst(rst),
        .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr),
        .m_dat_ms(m_dat_ms), .m_sel(m_sel), .m_cti(m_cti), .m_bte(m_bte),
        .m_ack(a_ack), .m_err(a_err), .m_rty(a_rty), .m_dat_sm(a_dat_sm),
        .s_cyc(a_cyc), .s_stb(a_stb), .s_we(a_we), .s_adr(a_adr),
        .s_dat_ms(a_dat), .s_sel(a_sel), .s_cti(a_cti), .s_bte(a_bte),
        .s_ack(s_ack), .s_err(s_err), .s_rty(s_rty), .s_dat_sm(s_dat_sm),
        .gnt(a_gnt)
    );

    wshb_arbiter #(.NM(NM), .AW(AW), .DW(DW), .MAX_HOLD(0)) dut_nohold (
        .clk(clk), .rst(rst),
        .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr),
        .m_dat_ms(m_dat_ms), .m_sel(m_sel), .m_cti(m_cti), .m_bte(m_bte),
        .m_ack(b_ack), .m_err(b_err), .m_rty(b_rty), .m_dat_sm(b_dat_sm),
        .s_cyc(b_cyc), .s_stb(b_stb), .s_we(b_we), .s_adr(b_adr),
        .s_dat_ms(b_dat), .s_sel(b_sel), .s_cti(b_cti), .s_bte(b_bte),
        .s_ack(s_ack), .s_err(s_err), .s_rty(s_rty), .s_dat_sm(s_dat_sm),
        .gnt(b_gnt)
    );

    typedef struct {
        logic [1:0] cyc;
        logic [1:0] stb;
        logic [2:0] cti0;
        logic [2:0] cti1;
        logic       ack;
        logic       err;
        logic       rty;
        logic [1:0] gnt;
        logic [1:0] ack_o;
        logic [1:0] err_o;
        logic [1:0] rty_o;
    } vec_t;

    int   n_chk  = 0;
    int   n_fail = 0;
    vec_t sb[$];
    vec_t tbl[25];

    function automatic vec_t mk(input logic [1:0] cyc, input logic [1:0] stb,
                                input logic ack, input logic err, input logic rty,
                                input logic [1:0] gnt, input logic [1:0] ack_o,
                                input logic [1:0] err_o, input logic [1:0] rty_o);
        vec_t v;
        v.cyc = cyc; v.stb = stb; v.cti0 = 3'b000; v.cti1 = 3'b000;
        v.ack = ack; v.err = err; v.rty = rty;
        v.gnt = gnt; v.ack_o = ack_o; v.err_o = err_o; v.rty_o = rty_o;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        m_cyc = v.cyc;
        m_stb = v.stb;
        m_cti = {v.cti1, v.cti0};
        s_ack = v.ack;
        s_err = v.err;
        s_rty = v.rty;
        sb.push_back(v);
    endtask

    task automatic pop(output vec_t e, output bit ok);
        ok = (sb.size() != 0);
        if (ok) e = sb.pop_front();
        else chk("scoreboard_empty", 64'(sb.size()), 64'(1));
    endtask

    // Full comparison of the hold-limit-4 instance; optionally the grant of the other one too
    task automatic check_a(input string tag, input bit with_b);
        vec_t e;
        bit   ok;
        logic o;
        logic has;
        pop(e, ok);
        if (ok) begin
            has = (e.gnt != 2'b00);
            o   = e.gnt[1];
            chk({tag, ".gnt"},    64'(a_gnt),    64'(e.gnt));
            chk({tag, ".s_cyc"},  64'(a_cyc),    64'(has ? e.cyc[o] : 1'b0));
            chk({tag, ".s_stb"},  64'(a_stb),    64'(has ? e.stb[o] : 1'b0));
            chk({tag, ".s_we"},   64'(a_we),     64'(has & o));
            chk({tag, ".s_adr"},  64'(a_adr),    64'(has ? (o ? ADR1 : ADR0) : 32'h0));
            chk({tag, ".s_dat"},  64'(a_dat),    64'(has ? (o ? DAT1 : DAT0) : 32'h0));
            chk({tag, ".s_sel"},  64'(a_sel),    64'(has ? (o ? SEL1 : SEL0) : 4'h0));
            chk({tag, ".s_cti"},  64'(a_cti),    64'(has ? (o ? e.cti1 : e.cti0) : 3'b000));
            chk({tag, ".s_bte"},  64'(a_bte),    64'(has ? (o ? BTE1 : BTE0) : 2'b00));
            chk({tag, ".m_ack"},  64'(a_ack),    64'(e.ack_o));
            chk({tag, ".m_err"},  64'(a_err),    64'(e.err_o));
            chk({tag, ".m_rty"},  64'(a_rty),    64'(e.rty_o));
            chk({tag, ".m_dat"},  a_dat_sm,      {e.gnt[1] ? SDAT : 32'h0, e.gnt[0] ? SDAT : 32'h0});
            if (with_b) chk({tag, ".nohold_gnt"}, 64'(b_gnt), 64'(e.gnt));
        end
    endtask

    task automatic check_b(input string tag);
        vec_t e;
        bit   ok;
        pop(e, ok);
        if (ok) begin
            chk({tag, ".gnt"},   64'(b_gnt), 64'(e.gnt));
            chk({tag, ".s_cyc"}, 64'(b_cyc), 64'((e.gnt != 2'b00) ? e.cyc[e.gnt[1]] : 1'b0));
            chk({tag, ".m_ack"}, 64'(b_ack), 64'(e.ack_o));
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t v;

        tbl[0]  = mk(2'b11, 2'b11, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00);
        tbl[1]  = mk(2'b11, 2'b11, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00);
        tbl[2]  = mk(2'b11, 2'b11, 1, 0, 0, 2'b01, 2'b01, 2'b00, 2'b00);
        tbl[3]  = mk(2'b10, 2'b10, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00);
        tbl[4]  = mk(2'b10, 2'b10, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00);
        tbl[5]  = mk(2'b10, 2'b10, 1, 0, 0, 2'b10, 2'b10, 2'b00, 2'b00);
        tbl[6]  = mk(2'b00, 2'b00, 0, 0, 0, 2'b10, 2'b00, 2'b00, 2'b00);
        tbl[7]  = mk(2'b11, 2'b11, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00);
        tbl[8]  = mk(2'b11, 2'b11, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00);
        tbl[9]  = mk(2'b11, 2'b11, 0, 1, 0, 2'b01, 2'b00, 2'b01, 2'b00);
        tbl[10] = mk(2'b01, 2'b01, 0, 0, 1, 2'b01, 2'b00, 2'b00, 2'b01);
        tbl[11] = mk(2'b00, 2'b00, 1, 0, 0, 2'b01, 2'b01, 2'b00, 2'b00);
        tbl[12] = mk(2'b00, 2'b00, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00);
        tbl[13] = mk(2'b10, 2'b10, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00);
        tbl[14] = mk(2'b10, 2'b10, 0, 1, 0, 2'b10, 2'b00, 2'b10, 2'b00);
        tbl[15] = mk(2'b00, 2'b00, 0, 0, 0, 2'b10, 2'b00, 2'b00, 2'b00);
        tbl[16] = mk(2'b00, 2'b00, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00);
        tbl[17] = mk(2'b10, 2'b00, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00);
        tbl[18] = mk(2'b10, 2'b00, 0, 0, 0, 2'b10, 2'b00, 2'b00, 2'b00);
        tbl[19] = mk(2'b10, 2'b10, 0, 0, 0, 2'b10, 2'b00, 2'b00, 2'b00);
        tbl[20] = mk(2'b10, 2'b10, 0, 0, 0, 2'b10, 2'b00, 2'b00, 2'b00);
        tbl[21] = mk(2'b10, 2'b10, 0, 0, 0, 2'b10, 2'b00, 2'b00, 2'b00);
        tbl[22] = mk(2'b10, 2'b10, 1, 0, 0, 2'b10, 2'b10, 2'b00, 2'b00);
        tbl[23] = mk(2'b00, 2'b00, 0, 0, 0, 2'b10, 2'b00, 2'b00, 2'b00);
        tbl[24] = mk(2'b00, 2'b00, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00);

        m_we     = 2'b10;
        m_adr    = {ADR1, ADR0};
        m_dat_ms = {DAT1, DAT0};
        m_sel    = {SEL1, SEL0};
        m_bte    = {BTE1, BTE0};
        s_dat_sm = SDAT;
        m_cti    = '0;

        // Reset held with both masters requesting and the slave terminating
        rst   = 1'b1;
        m_cyc = 2'b11;
        m_stb = 2'b11;
        s_ack = 1'b1;
        s_err = 1'b1;
        s_rty = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset.gnt",    64'(a_gnt), 64'(0));
        chk("reset.s_cyc",  64'(a_cyc), 64'(0));
        chk("reset.m_ack",  64'(a_ack), 64'(0));
        chk("reset.m_err",  64'(a_err), 64'(0));
        chk("reset.m_dat",  a_dat_sm,   64'(0));
        chk("reset.nohold_gnt", 64'(b_gnt), 64'(0));
        next_cycle();
        rst = 1'b0;

        for (int r = 0; r < 25; r++) begin
            drive(tbl[r]);
            @(negedge clk);
            check_a($sformatf("row%0d", r), 1'b1);
            next_cycle();
        end

        // Master 0 streams 8-beat bursts against a waiting master 1
        drive(mk(2'b11, 2'b11, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00));
        @(negedge clk); check_a("pre.idle", 1'b0); next_cycle();
        for (int b = 0; b < 8; b++) begin
            v = mk(2'b11, 2'b11, 1, 0, 0, 2'b01, 2'b01, 2'b00, 2'b00);
            v.cti0 = (b == 7) ? 3'b111 : 3'b010;
            drive(v);
            @(negedge clk); check_a($sformatf("pre.beat%0d", b), 1'b0); next_cycle();
        end
        drive(mk(2'b11, 2'b11, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00));
        @(negedge clk); check_a("pre.bubble", 1'b0); next_cycle();
        drive(mk(2'b11, 2'b11, 0, 0, 0, 2'b10, 2'b00, 2'b00, 2'b00));
        @(negedge clk); check_a("pre.m1_gnt", 1'b0); next_cycle();
        drive(mk(2'b11, 2'b11, 1, 0, 0, 2'b10, 2'b10, 2'b00, 2'b00));
        @(negedge clk); check_a("pre.m1_ack", 1'b0); next_cycle();
        drive(mk(2'b01, 2'b01, 0, 0, 0, 2'b10, 2'b00, 2'b00, 2'b00));
        @(negedge clk); check_a("pre.m1_drop", 1'b0); next_cycle();
        drive(mk(2'b01, 2'b01, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00));
        @(negedge clk); check_a("pre.bubble2", 1'b0); next_cycle();
        drive(mk(2'b01, 2'b01, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00));
        @(negedge clk); check_a("pre.m0_regnt", 1'b0); next_cycle();

        // Asynchronous reset in the middle of a granted transfer
        drive(mk(2'b01, 2'b01, 1, 0, 0, 2'b01, 2'b01, 2'b00, 2'b00));
        #1;
        check_a("arst.before", 1'b0);
        rst = 1'b1;
        #1;
        chk("arst.gnt",   64'(a_gnt), 64'(0));
        chk("arst.s_cyc", 64'(a_cyc), 64'(0));
        chk("arst.s_adr", 64'(a_adr), 64'(0));
        chk("arst.m_ack", 64'(a_ack), 64'(0));
        chk("arst.nohold_gnt", 64'(b_gnt), 64'(0));
        next_cycle();
        rst = 1'b0;

        // Without a hold limit master 0 keeps the bus for 1000 acks
        drive(mk(2'b11, 2'b11, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00));
        @(negedge clk); check_a("nohold.idle", 1'b1); next_cycle();
        for (int k = 0; k < 1000; k++) begin
            drive(mk(2'b11, 2'b11, 1, 0, 0, 2'b01, 2'b01, 2'b00, 2'b00));
            @(negedge clk);
            check_b($sformatf("nohold.ack%0d", k));
            if (k == 4) chk("hold4.single_beat_bubble", 64'(a_gnt), 64'(2'b00));
            if (k == 5) chk("hold4.single_beat_switch", 64'(a_gnt), 64'(2'b10));
            next_cycle();
        end
        drive(mk(2'b10, 2'b10, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00));
        @(negedge clk); check_b("nohold.drop"); next_cycle();
        drive(mk(2'b10, 2'b10, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00));
        @(negedge clk); check_b("nohold.bubble"); next_cycle();
        drive(mk(2'b10, 2'b10, 0, 0, 0, 2'b10, 2'b00, 2'b00, 2'b00));
        @(negedge clk); check_b("nohold.m1_gnt"); next_cycle();

        chk("scoreboard_drained", 64'(sb.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
